// File: rtl/rv_ctrl_pkg.sv
// Shared control definitions for the RV32I multicycle controller: sequencer
// state encoding and the opcode constants also used by control_unit.
package rv_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        DECODE  = 3'd2,
        EXECUTE = 3'd3,
        MEM     = 3'd4,
        WB      = 3'd5,
        FAULT   = 3'd7
    } seq_state_t;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;

endpackage

// File: rtl/seq_timeout_ctr.sv
// Memory wait-cycle counter. expired is high during the last wait cycle that
// is still allowed, so the sequencer can leave for FAULT on that edge.
module seq_timeout_ctr #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

    logic [CW-1:0] count;

    // Saturate at LAST; the sequencer changes state (and thus clears) there.
    always_ff @(posedge clk) begin
        if (rst || clear)
            count <= '0;
        else if (enable && !expired)
            count <= count + 1'b1;
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle RV32I sequencer: walks one instruction through
// FETCH/DECODE/EXECUTE/MEM/WB, owns the PC and retired counter, and faults on memory timeout.
module multicycle_sequencer
    import rv_ctrl_pkg::*;
#(
    parameter int          MEM_TIMEOUT = 15,
    parameter logic [31:0] PC_RESET    = 32'h0000_0000,
    parameter logic [31:0] PC_STEP     = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        halt,
    input  logic        is_load,
    input  logic        is_store,
    input  logic        write_en,
    input  logic        illegal,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic        ir_en,
    output logic        alu_en,
    output logic        rf_we,
    output logic        wb_sel,
    output logic [31:0] pc,
    output logic [31:0] retired,
    output logic [2:0]  state,
    output logic        busy,
    output logic        fault
);

    seq_state_t  state_q, state_next;
    seq_state_t  retire_target;
    logic [31:0] pc_q, retired_q;
    logic        waiting, expired, retire, mem_op;

    assign mem_op        = is_load | is_store;
    assign retire_target = halt ? IDLE : FETCH;
    assign waiting       = ((state_q == FETCH) && !imem_ack) || ((state_q == MEM) && !dmem_ack);
    assign retire        = ((state_q == EXECUTE) && !mem_op && !write_en)
                         || ((state_q == MEM) && dmem_ack && !is_load)
                         || (state_q == WB);

    seq_timeout_ctr #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_next != state_q),
        .enable (waiting),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_next;
    end

    // An ack in the same cycle as expiry still counts as a completed access.
    always_comb begin
        state_next = state_q;
        case (state_q)
            IDLE:    if (start) state_next = FETCH;
            FETCH: begin
                if (imem_ack)     state_next = DECODE;
                else if (expired) state_next = FAULT;
            end
            DECODE:  state_next = (illegal || (is_load && is_store)) ? FAULT : EXECUTE;
            EXECUTE: begin
                if (mem_op)        state_next = MEM;
                else if (write_en) state_next = WB;
                else               state_next = retire_target;
            end
            MEM: begin
                if (dmem_ack)     state_next = is_load ? WB : retire_target;
                else if (expired) state_next = FAULT;
            end
            WB:      state_next = retire_target;
            FAULT:   state_next = FAULT;
            default: state_next = FAULT;
        endcase
    end

    always_comb begin
        imem_req = 1'b0;
        ir_en    = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        alu_en   = 1'b0;
        rf_we    = 1'b0;
        wb_sel   = 1'b0;
        case (state_q)
            FETCH: begin
                imem_req = 1'b1;
                ir_en    = imem_ack;
            end
            EXECUTE: alu_en = 1'b1;
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_store;
            end
            WB: begin
                rf_we  = 1'b1;
                wb_sel = is_load;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= PC_RESET;
            retired_q <= '0;
        end else if (retire) begin
            pc_q      <= pc_q + PC_STEP;
            retired_q <= retired_q + 32'd1;
        end
    end

    assign pc      = pc_q;
    assign retired = retired_q;
    assign state   = state_q;
    assign busy    = (state_q != IDLE) && (state_q != FAULT);
    assign fault   = (state_q == FAULT);

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed self-checking bench for multicycle_sequencer: one task per scenario,
// expected values computed by hand from the instruction timing.
module tb_multicycle_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, halt, is_load, is_store, write_en, illegal;
    logic        imem_ack, dmem_ack;
    logic        imem_req, dmem_req, dmem_we, ir_en, alu_en, rf_we, wb_sel, busy, fault;
    logic [31:0] pc, retired;
    logic [2:0]  state;

    int checks   = 0;
    int failures = 0;

    multicycle_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .halt(halt),
        .is_load(is_load), .is_store(is_store), .write_en(write_en), .illegal(illegal),
        .imem_req(imem_req), .imem_ack(imem_ack),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .ir_en(ir_en), .alu_en(alu_en), .rf_we(rf_we), .wb_sel(wb_sel),
        .pc(pc), .retired(retired), .state(state), .busy(busy), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        {start, halt, is_load, is_store, write_en, illegal, imem_ack, dmem_ack} = '0;
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        {start, halt, is_load, is_store, write_en, illegal, imem_ack, dmem_ack} = '0;
        cycle();
        cycle();
        checks++;
        if (state !== 3'd0 || pc !== 32'h0 || retired !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_regs: state=%0d pc=%h retired=%h, required 0/0/0", state, pc, retired);
        end
        checks++;
        if ({imem_req, dmem_req, ir_en, alu_en, rf_we, busy, fault} !== 7'b0) begin
            failures++;
            $display("[TB] FAIL reset_strobes: got %b, required 0000000",
                     {imem_req, dmem_req, ir_en, alu_en, rf_we, busy, fault});
        end
        rst = 1'b0;
    endtask

    task automatic test_alu();
        do_reset();
        start = 1'b1;
        cycle();
        start = 1'b0; imem_ack = 1'b1; write_en = 1'b1; halt = 1'b1;
        #1;
        checks++;
        if (state !== 3'd1 || imem_req !== 1'b1 || ir_en !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL alu_fetch: state=%0d req=%b ir_en=%b busy=%b, required 1/1/1/1", state, imem_req, ir_en, busy);
        end
        cycle();
        imem_ack = 1'b0;
        #1;
        checks++;
        if (state !== 3'd2 || ir_en !== 1'b0 || alu_en !== 1'b0) begin
            failures++;
            $display("[TB] FAIL alu_decode: state=%0d ir_en=%b alu_en=%b, required 2/0/0", state, ir_en, alu_en);
        end
        cycle();
        checks++;
        if (state !== 3'd3 || alu_en !== 1'b1 || rf_we !== 1'b0) begin
            failures++;
            $display("[TB] FAIL alu_execute: state=%0d alu_en=%b rf_we=%b, required 3/1/0", state, alu_en, rf_we);
        end
        cycle();
        checks++;
        if (state !== 3'd5 || rf_we !== 1'b1 || wb_sel !== 1'b0 || alu_en !== 1'b0 || pc !== 32'h0) begin
            failures++;
            $display("[TB] FAIL alu_wb: state=%0d rf_we=%b wb_sel=%b alu_en=%b pc=%h, required 5/1/0/0/0", state, rf_we, wb_sel, alu_en, pc);
        end
        cycle();
        checks++;
        if (state !== 3'd0 || pc !== 32'h4 || retired !== 32'd1 || busy !== 1'b0 || rf_we !== 1'b0) begin
            failures++;
            $display("[TB] FAIL alu_retire: state=%0d pc=%h retired=%0d busy=%b rf_we=%b, required 0/4/1/0/0", state, pc, retired, busy, rf_we);
        end
    endtask

    task automatic test_load();
        int req_cycles;
        req_cycles = 0;
        do_reset();
        start = 1'b1;
        cycle();
        start = 1'b0; imem_ack = 1'b1; is_load = 1'b1; write_en = 1'b1; halt = 1'b1;
        cycle();
        imem_ack = 1'b0;
        cycle();
        checks++;
        if (state !== 3'd3 || alu_en !== 1'b1) begin
            failures++;
            $display("[TB] FAIL load_execute: state=%0d alu_en=%b, required 3/1", state, alu_en);
        end
        for (int i = 0; i < 4; i++) begin
            cycle();
            dmem_ack = (i == 3);
            #1;
            if (dmem_req === 1'b1 && dmem_we === 1'b0 && state === 3'd4) req_cycles++;
        end
        checks++;
        if (req_cycles !== 4) begin
            failures++;
            $display("[TB] FAIL load_mem_wait: dmem_req read cycles=%0d, required 4", req_cycles);
        end
        cycle();
        dmem_ack = 1'b0;
        #1;
        checks++;
        if (state !== 3'd5 || rf_we !== 1'b1 || wb_sel !== 1'b1 || dmem_req !== 1'b0) begin
            failures++;
            $display("[TB] FAIL load_wb: state=%0d rf_we=%b wb_sel=%b dmem_req=%b, required 5/1/1/0", state, rf_we, wb_sel, dmem_req);
        end
        cycle();
        checks++;
        if (state !== 3'd0 || pc !== 32'h4 || retired !== 32'd1) begin
            failures++;
            $display("[TB] FAIL load_retire: state=%0d pc=%h retired=%0d, required 0/4/1", state, pc, retired);
        end
    endtask

    task automatic test_store_nop();
        int rf_seen;
        rf_seen = 0;
        do_reset();
        start = 1'b1;
        cycle();
        start = 1'b0; imem_ack = 1'b1; is_store = 1'b1;
        cycle();
        imem_ack = 1'b0;
        cycle();
        cycle();
        dmem_ack = 1'b1;
        #1;
        checks++;
        if (state !== 3'd4 || dmem_req !== 1'b1 || dmem_we !== 1'b1 || rf_we !== 1'b0) begin
            failures++;
            $display("[TB] FAIL store_mem: state=%0d req=%b we=%b rf_we=%b, required 4/1/1/0", state, dmem_req, dmem_we, rf_we);
        end
        cycle();
        dmem_ack = 1'b0; is_store = 1'b0; halt = 1'b1; imem_ack = 1'b1;
        #1;
        checks++;
        if (state !== 3'd1 || pc !== 32'h4 || retired !== 32'd1 || ir_en !== 1'b1) begin
            failures++;
            $display("[TB] FAIL store_retire: state=%0d pc=%h retired=%0d ir_en=%b, required 1/4/1/1", state, pc, retired, ir_en);
        end
        for (int i = 0; i < 2; i++) begin
            cycle();
            imem_ack = 1'b0;
            #1;
            if (rf_we !== 1'b0) rf_seen++;
        end
        cycle();
        checks++;
        if (state !== 3'd0 || pc !== 32'h8 || retired !== 32'd2 || rf_seen !== 0) begin
            failures++;
            $display("[TB] FAIL nop_retire: state=%0d pc=%h retired=%0d rf_we_cycles=%0d, required 0/8/2/0", state, pc, retired, rf_seen);
        end
    endtask

    task automatic test_timeout();
        int fetch_cycles;
        fetch_cycles = 0;
        do_reset();
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (state === 3'd1 && imem_req === 1'b1) fetch_cycles++;
            cycle();
        end
        checks++;
        if (fetch_cycles !== 15 || state !== 3'd7 || imem_req !== 1'b0 || fault !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL fetch_timeout: fetch_cycles=%0d state=%0d req=%b fault=%b busy=%b, required 15/7/0/1/0",
                     fetch_cycles, state, imem_req, fault, busy);
        end
        start = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1;
        cycle();
        cycle();
        checks++;
        if (state !== 3'd7 || fault !== 1'b1 || ir_en !== 1'b0 || pc !== 32'h0 || retired !== 32'h0) begin
            failures++;
            $display("[TB] FAIL fault_sticky: state=%0d fault=%b ir_en=%b pc=%h retired=%0d, required 7/1/0/0/0", state, fault, ir_en, pc, retired);
        end
        do_reset();
        checks++;
        if (state !== 3'd0 || fault !== 1'b0 || pc !== 32'h0) begin
            failures++;
            $display("[TB] FAIL fault_reset: state=%0d fault=%b pc=%h, required 0/0/0", state, fault, pc);
        end
    endtask

    task automatic test_illegal();
        int alu_seen;
        alu_seen = 0;
        do_reset();
        start = 1'b1;
        cycle();
        start = 1'b0; imem_ack = 1'b1; illegal = 1'b1; write_en = 1'b1;
        cycle();
        imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            if (alu_en !== 1'b0) alu_seen++;
        end
        checks++;
        if (state !== 3'd7 || fault !== 1'b1 || alu_seen !== 0) begin
            failures++;
            $display("[TB] FAIL illegal_fault: state=%0d fault=%b alu_cycles=%0d, required 7/1/0", state, fault, alu_seen);
        end
        do_reset();
        start = 1'b1;
        cycle();
        start = 1'b0; imem_ack = 1'b1; is_load = 1'b1; is_store = 1'b1;
        cycle();
        imem_ack = 1'b0;
        cycle();
        checks++;
        if (state !== 3'd7 || alu_en !== 1'b0 || dmem_req !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ldst_fault: state=%0d alu_en=%b dmem_req=%b, required 7/0/0", state, alu_en, dmem_req);
        end
    endtask

    task automatic test_halt_wrap();
        do_reset();
        force dut.retired_q = 32'hFFFF_FFFF;
        dmem_ack = 1'b1; imem_ack = 1'b1;
        cycle();
        release dut.retired_q;
        cycle();
        checks++;
        if (state !== 3'd0 || dmem_req !== 1'b0 || busy !== 1'b0 || retired !== 32'hFFFF_FFFF) begin
            failures++;
            $display("[TB] FAIL idle_stray_ack: state=%0d dmem_req=%b busy=%b retired=%h, required 0/0/0/ffffffff", state, dmem_req, busy, retired);
        end
        dmem_ack = 1'b0; imem_ack = 1'b0;
        start = 1'b1;
        cycle();
        imem_ack = 1'b1; halt = 1'b1;
        cycle();
        imem_ack = 1'b0;
        cycle();
        checks++;
        if (state !== 3'd3 || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL start_ignored: state=%0d busy=%b, required 3/1", state, busy);
        end
        start = 1'b0;
        cycle();
        checks++;
        if (state !== 3'd0 || busy !== 1'b0 || retired !== 32'h0 || pc !== 32'h4) begin
            failures++;
            $display("[TB] FAIL halt_wrap: state=%0d busy=%b retired=%h pc=%h, required 0/0/00000000/4", state, busy, retired, pc);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store_nop();
        test_timeout();
        test_illegal();
        test_halt_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
